// File: rtl/trafficgen_sched_pkg.sv
// Shared types and constants for the trafficgen register-slave scheduler.
// Optional address checking is enabled with TRAFFICGEN_SCHED_ADDR_CHECK_EN.
package trafficgen_sched_pkg;

  typedef enum logic [2:0] {IDLE, WR, WB, RD, RR, RSP} state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  typedef struct packed {
    state_t state;
    logic   cmd_addr_bad;
  } dbg_t;

  // True when a byte address is misaligned or outside the implemented registers.
  function automatic logic addr_bad(input logic [31:0] addr, input int num_regs);
    return (addr[1:0] != 2'b00) || (addr >= 32'(num_regs * 4));
  endfunction

endpackage

// File: rtl/trafficgen_rr_arb.sv
// Combinational round-robin picker: first set request at or above ptr_i, with wrap.
module trafficgen_rr_arb #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any_o && req_i[(int'(ptr_i) + i) % N]) begin
        any_o = 1'b1;
        gnt_o[(int'(ptr_i) + i) % N] = 1'b1;
        idx_o = IW'((int'(ptr_i) + i) % N);
      end
    end
  end

endmodule

// File: rtl/trafficgen_sched.sv
// Round-robin scheduler serialising requester commands onto one AXI4-Lite master.
// Define TRAFFICGEN_SCHED_ADDR_CHECK_EN to answer bad addresses locally with DECERR.
module trafficgen_sched
  import trafficgen_sched_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 4
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic [ADDR_W-1:0]         m_axi_awaddr,
  output logic [2:0]                m_axi_awprot,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [DATA_W-1:0]         m_axi_wdata,
  output logic [DATA_W/8-1:0]       m_axi_wstrb,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  output logic [ADDR_W-1:0]         m_axi_araddr,
  output logic [2:0]                m_axi_arprot,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [DATA_W-1:0]         m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready,
  output dbg_t                      dbg_o
);

  localparam int IW = $clog2(NUM_REQ);

  // Every channel is valid/ready: a beat transfers on a cycle where both are high;
  // a valid, once raised, stays high with stable payload until its ready.
  state_t              state_q, state_d;
  logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]       g_q, g_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          resp_q, resp_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;

  logic [NUM_REQ-1:0]  arb_gnt;
  logic [IW-1:0]       arb_idx;
  logic                arb_any;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                aw_hs, w_hs;

  trafficgen_rr_arb #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  assign sel_addr  = req_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
  assign sel_wdata = req_wdata[int'(arb_idx)*DATA_W +: DATA_W];
  assign aw_hs     = (state_q == WR) && !aw_done_q && m_axi_awready;
  assign w_hs      = (state_q == WR) && !w_done_q && m_axi_wready;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      g_q       <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= RESP_OKAY;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      g_q       <= g_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    g_d       = g_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          g_d       = arb_idx;
          we_d      = req_we[arb_idx];
          addr_d    = sel_addr;
          wdata_d   = sel_wdata;
          rr_ptr_d  = (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
`ifdef TRAFFICGEN_SCHED_ADDR_CHECK_EN
          if (addr_bad(32'(sel_addr), NUM_REGS)) begin
            state_d = RSP;
            resp_d  = RESP_DECERR;
            rdata_d = '0;
          end else begin
            state_d = req_we[arb_idx] ? WR : RD;
          end
`else
          state_d = req_we[arb_idx] ? WR : RD;
`endif
        end
      end
      WR: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = WB;
      end
      WB: begin
        if (m_axi_bvalid) begin
          resp_d  = m_axi_bresp;
          rdata_d = '0;
          state_d = RSP;
        end
      end
      RD: if (m_axi_arready) state_d = RR;
      RR: begin
        if (m_axi_rvalid) begin
          rdata_d = m_axi_rdata;
          resp_d  = m_axi_rresp;
          state_d = RSP;
        end
      end
      RSP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready     = '0;
    rsp_valid     = '0;
    rsp_rdata     = '0;
    rsp_resp      = RESP_OKAY;
    m_axi_awaddr  = addr_q;
    m_axi_awprot  = PROT_DEFAULT;
    m_axi_awvalid = (state_q == WR) && !aw_done_q;
    m_axi_wdata   = wdata_q;
    m_axi_wstrb   = '1;
    m_axi_wvalid  = (state_q == WR) && !w_done_q;
    m_axi_bready  = (state_q == WB);
    m_axi_araddr  = addr_q;
    m_axi_arprot  = PROT_DEFAULT;
    m_axi_arvalid = (state_q == RD);
    m_axi_rready  = (state_q == RR);
    // Never accept a command while reset is being applied.
    if (state_q == IDLE && !ARESET) req_ready = arb_gnt;
    if (state_q == RSP) begin
      rsp_valid[g_q] = 1'b1;
      rsp_rdata      = rdata_q;
      rsp_resp       = resp_q;
    end
    dbg_o.state        = state_q;
    dbg_o.cmd_addr_bad = addr_bad(32'(addr_q), NUM_REGS);
  end

endmodule

// File: tb/tb_trafficgen_sched.sv
// Directed bench for trafficgen_sched with a small AXI4-Lite register slave model.
// Expectations for bad addresses follow TRAFFICGEN_SCHED_ADDR_CHECK_EN.
module tb_trafficgen_sched;
  import trafficgen_sched_pkg::*;

  localparam int NR = 2;
  localparam int AW = 5;
  localparam int DW = 32;

  logic              ACLK = 1'b0;
  logic              ARESET = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_we = '0;
  logic [NR*AW-1:0]  req_addr = '0;
  logic [NR*DW-1:0]  req_wdata = '0;
  logic [NR-1:0]     req_ready, rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic [1:0]        rsp_resp;
  logic [AW-1:0]     m_axi_awaddr, m_axi_araddr;
  logic [2:0]        m_axi_awprot, m_axi_arprot;
  logic              m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [DW-1:0]     m_axi_wdata, m_axi_rdata;
  logic [DW/8-1:0]   m_axi_wstrb;
  logic [1:0]        m_axi_bresp, m_axi_rresp;
  logic              m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic              m_axi_rvalid, m_axi_rready;
  dbg_t              dbg;

  int n_cmp = 0;
  int n_err = 0;

  trafficgen_sched #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .NUM_REGS(4)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .dbg_o(dbg)
  );

  // ---------------- clock ----------------
  always #5 ACLK = ~ACLK;

  // ---------------- slave model ----------------
  logic [31:0]   mem [4];
  int            aw_delay = 0;
  int            aw_cnt;
  int            aw_n = 0, w_n = 0, ar_n = 0;
  logic          aw_got, w_got;
  logic [AW-1:0] aw_a;
  logic [31:0]   w_d;
  logic          aw_hs, w_hs, ar_hs, aw_have, w_have;
  logic [AW-1:0] aw_addr_now;
  logic [31:0]   w_data_now;

  assign m_axi_awready = m_axi_awvalid && (aw_cnt >= aw_delay);
  assign m_axi_wready  = m_axi_wvalid;
  assign m_axi_arready = m_axi_arvalid;
  assign aw_hs       = m_axi_awvalid && m_axi_awready;
  assign w_hs        = m_axi_wvalid && m_axi_wready;
  assign ar_hs       = m_axi_arvalid && m_axi_arready;
  assign aw_have     = aw_got || aw_hs;
  assign w_have      = w_got || w_hs;
  assign aw_addr_now = aw_hs ? m_axi_awaddr : aw_a;
  assign w_data_now  = w_hs ? m_axi_wdata : w_d;

  always @(posedge ACLK) begin
    if (ARESET) begin
      m_axi_bvalid <= 1'b0;
      m_axi_rvalid <= 1'b0;
      m_axi_bresp  <= 2'b00;
      m_axi_rresp  <= 2'b00;
      m_axi_rdata  <= '0;
      aw_got       <= 1'b0;
      w_got        <= 1'b0;
      aw_cnt       <= 0;
    end else begin
      if (aw_hs) begin aw_a <= m_axi_awaddr; aw_n <= aw_n + 1; end
      if (w_hs)  begin w_d <= m_axi_wdata;   w_n  <= w_n + 1;  end
      if (aw_hs) aw_cnt <= 0;
      else if (m_axi_awvalid) aw_cnt <= aw_cnt + 1;
      if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
      if (aw_have && w_have) begin
        aw_got       <= 1'b0;
        w_got        <= 1'b0;
        m_axi_bvalid <= 1'b1;
        if (aw_addr_now < 5'h10) begin
          mem[aw_addr_now[3:2]] <= w_data_now;
          m_axi_bresp <= 2'b00;
        end else begin
          m_axi_bresp <= 2'b11;
        end
      end else begin
        aw_got <= aw_have;
        w_got  <= w_have;
      end
      if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
      if (ar_hs) begin
        ar_n         <= ar_n + 1;
        m_axi_rvalid <= 1'b1;
        m_axi_rdata  <= (m_axi_araddr >= 5'h10) ? 32'h0 : mem[m_axi_araddr[3:2]];
        m_axi_rresp  <= (m_axi_araddr >= 5'h10) ? 2'b11 :
                        (m_axi_araddr == 5'h0C) ? 2'b10 : 2'b00;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge ACLK);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input int r, input bit we, input logic [AW-1:0] a, input logic [31:0] d);
    req_valid[r] = 1'b1;
    req_we[r]    = we;
    req_addr[r*AW +: AW]  = a;
    req_wdata[r*DW +: DW] = d;
  endtask

  // Issues one command from an idle DUT and checks grant, latency and response.
  task automatic do_cmd(input int r, input bit we, input logic [AW-1:0] a, input logic [31:0] d,
                        input int exp_lat, input logic [31:0] exp_rd, input logic [1:0] exp_resp,
                        input string tag);
    int w;
    step();
    put(r, we, a, d);
    #1;
    chk({tag, "_ready"}, req_ready, 64'(1 << r));
    step();
    req_valid[r] = 1'b0;
    w = 1;
    while (rsp_valid == '0 && w < 20) begin
      step();
      w++;
    end
    chk({tag, "_lat"}, w, exp_lat);
    chk({tag, "_rspv"}, rsp_valid, 64'(1 << r));
    chk({tag, "_rdata"}, rsp_rdata, exp_rd);
    chk({tag, "_resp"}, rsp_resp, exp_resp);
  endtask

  // ---------------- stimulus and checks ----------------
  initial begin
    int cnt [2];
    int w;
    int g;
    int hs0;

    // Reset: outputs idle, no grant even with a request pending.
    req_valid[0] = 1'b1;
    step();
    step();
    chk("rst_ready", req_ready, 0);
    chk("rst_rspv", rsp_valid, 0);
    chk("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_state", dbg.state, IDLE);
    chk("const_wstrb", m_axi_wstrb, 4'hF);
    chk("const_prot", {m_axi_awprot, m_axi_arprot}, 0);
    req_valid[0] = 1'b0;
    ARESET = 1'b0;

    // Write 0x4 <- 2 from requester 0, cycle by cycle.
    step();
    put(0, 1'b1, 5'h04, 32'h2);
    #1;
    chk("wr_ready", req_ready, 2'b01);
    step();
    req_valid[0] = 1'b0;
    chk("wr_c1_awvalid", m_axi_awvalid, 1);
    chk("wr_c1_wvalid", m_axi_wvalid, 1);
    chk("wr_c1_awaddr", m_axi_awaddr, 5'h04);
    chk("wr_c1_wdata", m_axi_wdata, 32'h2);
    step();
    chk("wr_c2_bready", m_axi_bready, 1);
    chk("wr_c2_awvalid", m_axi_awvalid, 0);
    step();
    chk("wr_c3_rspv", rsp_valid, 2'b01);
    chk("wr_c3_resp", rsp_resp, 2'b00);
    chk("wr_c3_rdata", rsp_rdata, 0);
    step();
    chk("wr_c4_rspv", rsp_valid, 0);
    do_cmd(0, 1'b0, 5'h04, 32'h0, 3, 32'h2, 2'b00, "rd4");

    // Both requesters streaming writes after a fresh reset: grants alternate from 0.
    ARESET = 1'b1;
    step();
    ARESET = 1'b0;
    cnt[0] = 0;
    cnt[1] = 0;
    put(0, 1'b1, 5'h00, 32'hA0);
    put(1, 1'b1, 5'h08, 32'hB0);
    #1;
    for (int n = 0; n < 8; n++) begin
      w = 0;
      while (req_ready == '0 && w < 10) begin
        step();
        w++;
      end
      g = n % 2;
      chk("rr_grant", req_ready, (g == 0) ? 2'b01 : 2'b10);
      step();
      chk("rr_awaddr", m_axi_awaddr, (g == 0) ? 5'h00 : 5'h08);
      chk("rr_wdata", m_axi_wdata, ((g == 0) ? 32'hA0 : 32'hB0) + 32'(cnt[g]));
      cnt[g]++;
      if (cnt[g] == 4) req_valid[g] = 1'b0;
      else req_wdata[g*DW +: DW] = ((g == 0) ? 32'hA0 : 32'hB0) + 32'(cnt[g]);
    end
    step();
    step();
    step();
    do_cmd(0, 1'b0, 5'h00, 32'h0, 3, 32'hA3, 2'b00, "rb0");
    do_cmd(1, 1'b0, 5'h08, 32'h0, 3, 32'hB3, 2'b00, "rb8");

    // AW ready delayed three cycles, W ready immediate.
    aw_delay = 3;
    step();
    put(0, 1'b1, 5'h0C, 32'h55);
    #1;
    chk("skew_ready", req_ready, 2'b01);
    step();
    req_valid[0] = 1'b0;
    chk("skew_c1", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 3'b110);
    step();
    chk("skew_c2", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 3'b100);
    step();
    chk("skew_c3", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 3'b100);
    step();
    chk("skew_c4", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 3'b100);
    step();
    chk("skew_c5", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 3'b001);
    step();
    chk("skew_rspv", rsp_valid, 2'b01);
    chk("skew_resp", rsp_resp, 2'b00);
    aw_delay = 0;

    // Slave error on read of 0xC, routed to requester 1 only.
    do_cmd(1, 1'b0, 5'h0C, 32'h0, 3, 32'h55, 2'b10, "slverr");

    // Reset while in RR with the read beat pending.
    step();
    put(0, 1'b0, 5'h00, 32'h0);
    #1;
    chk("rrst_ready", req_ready, 2'b01);
    step();
    req_valid[0] = 1'b0;
    chk("rrst_arvalid", m_axi_arvalid, 1);
    step();
    chk("rrst_rready", m_axi_rready, 1);
    ARESET = 1'b1;
    step();
    ARESET = 1'b0;
    chk("rrst_rspv", rsp_valid, 0);
    chk("rrst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 0);
    chk("rrst_state", dbg.state, IDLE);
    step();
    chk("rrst_rspv2", rsp_valid, 0);
    put(0, 1'b1, 5'h00, 32'h11);
    put(1, 1'b1, 5'h04, 32'h22);
    #1;
    chk("rrst_grant", req_ready, 2'b01);
    step();
    req_valid = '0;
    w = 1;
    while (rsp_valid == '0 && w < 20) begin
      step();
      w++;
    end
    chk("rrst_lat", w, 3);
    chk("rrst_rsp", {rsp_valid, rsp_resp}, {2'b01, 2'b00});
    step();
    step();
    chk("rrst_nograb", req_ready, 0);

    // Misaligned / out-of-range addresses.
    hs0 = aw_n + w_n + ar_n;
`ifdef TRAFFICGEN_SCHED_ADDR_CHECK_EN
    do_cmd(0, 1'b0, 5'h10, 32'h0, 1, 32'h0, 2'b11, "chk_rd10");
    do_cmd(0, 1'b1, 5'h06, 32'h99, 1, 32'h0, 2'b11, "chk_wr6");
    step();
    chk("chk_no_hs", aw_n + w_n + ar_n - hs0, 0);
`else
    do_cmd(0, 1'b0, 5'h10, 32'h0, 3, 32'h0, 2'b11, "fwd_rd10");
    do_cmd(0, 1'b1, 5'h06, 32'h99, 3, 32'h0, 2'b00, "fwd_wr6");
    step();
    chk("fwd_hs", aw_n + w_n + ar_n - hs0, 3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/trafficgen_sched.md
Name: trafficgen_sched

Overview:
- Round-robin scheduler that shares the trafficgen AXI4-Lite register slave (4 × 32-bit registers, byte addresses 0x0–0xC) between NUM_REQ on-chip requesters.
- Each requester issues single-word read or write commands over a simple valid/ready port.
- The block serialises the commands onto one AXI4-Lite master port, with one transaction outstanding at a time.
- It returns the read data and response code to the originating requester. It sits between the control agents and the trafficgen S00_AXI port in the block design.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_W, 4, AXI4-Lite address width
DATA_W, 32, data width (fixed 32; wstrb width DATA_W/8)
NUM_REGS, 4, implemented slave registers (used only with the optional feature)

Ports:
ACLK  in  1  clock
ARESET  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  command valid per requester
req_we  in  NUM_REQ  1=write, 0=read
req_addr  in  NUM_REQ*ADDR_W  packed byte addresses
req_wdata  in  NUM_REQ*DATA_W  packed write data
req_ready  out  NUM_REQ  one-hot pulse: command accepted
rsp_valid  out  NUM_REQ  one-hot pulse: response available
rsp_rdata  out  DATA_W  read data (0 for writes), shared across requesters
rsp_resp  out  2  AXI resp code, shared across requesters
m_axi_awaddr/awprot/awvalid/awready  out/out/out/in  ADDR_W/3/1/1  write address channel
m_axi_wdata/wstrb/wvalid/wready  out/out/out/in  DATA_W/DATA_W/8/1/1  write data channel
m_axi_bresp/bvalid/bready  in/in/out  2/1/1  write response channel
m_axi_araddr/arprot/arvalid/arready  out/out/out/in  ADDR_W/3/1/1  read address channel
m_axi_rdata/rresp/rvalid/rready  in/in/in/out  DATA_W/2/1/1  read data channel

Behaviour:
- Reset: all outputs 0; FSM=IDLE; rr_ptr=0.
- ARESET asserted mid-transaction:
  - All valids and readies drop on the next edge.
  - The pending command is discarded; no rsp_valid is issued.
- Constants: awprot=arprot=3'b000; wstrb=all ones.
- FSM IDLE: if any req_valid is set, grant the first set bit searching from rr_ptr upward with wrap.
  - Pulse req_ready[g] in that cycle.
  - Latch we/addr/wdata/g.
  - Set rr_ptr=(g+1) mod NUM_REQ.
  - Next state WR when we=1, otherwise RD.
- A requester must hold its command until its req_ready pulse. req_ready never pulses for an idle requester.
- WR:
  - awvalid and wvalid both assert in the first WR cycle.
  - Each deasserts independently on its own ready handshake.
  - When both handshakes are complete (possibly in the same cycle), go to WB.
- WB: bready=1. On bvalid, latch bresp and set rdata=0. Go to RSP.
- RD: arvalid=1 until arready, then go to RR.
- RR: rready=1. On rvalid, latch rdata and rresp. Go to RSP.
- RSP:
  - One cycle with rsp_valid[g]=1 and rsp_rdata/rsp_resp valid.
  - Next state IDLE.
  - No new grant is made in this cycle.
- Minimum latency with zero-wait slave: accept (cycle 0) → AW/W (cycle 1) → bvalid sampled (cycle 2) → rsp_valid (cycle 3). Reads follow the same timing.
- Requesters cannot back-pressure responses; rsp is a single-cycle pulse.
- Addresses pass through unmodified. Low 2 bits are forwarded as given.
- A requester that deasserts req_valid without a req_ready pulse loses nothing; no state is held for it.

Optional Feature:
- Macro TRAFFICGEN_SCHED_ADDR_CHECK_EN.
- Defined:
  - At grant, a command with addr[1:0]!=0 or addr>=NUM_REGS*4 skips AXI.
  - The FSM goes straight to RSP with rsp_resp=2'b11 (DECERR) and rsp_rdata=0.
  - Latency from accept to response is 1 cycle.
  - No AXI activity is generated.
- Undefined: every address is forwarded and the slave's response is reported verbatim.

Decomposition:
- Package trafficgen_sched_pkg holds:
  - state_t enum {IDLE, WR, WB, RD, RR, RSP}
  - AXI resp constants (RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11)
  - PROT_DEFAULT
- Sub-module trafficgen_rr_arb: NUM_REQ-wide round-robin priority picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant, index, any.
  - Purely combinational.
  - The pointer register lives in the parent.

Test Plan:
- Write then read, requester 0 alone:
  - Write 0x4 ← 0x00000002; slave zero-wait → AW/W at cycle 1, rsp_valid[0] at cycle 3 with resp=00.
  - Read 0x4 → rsp_rdata=0x00000002.
- Both requesters hold writes continuously (req0: addr 0x0, data 0xA0+n; req1: addr 0x8, data 0xB0+n):
  - Grants alternate 0,1,0,1 over 8 commands.
  - Final readback gives 0xA3 and 0xB3.
- Slave skew: awready delayed 3 cycles, wready immediate:
  - wvalid drops after 1 cycle.
  - awvalid is held for 4 cycles.
  - bready asserts only after both handshakes.
- Slave returns rresp=2'b10 on read of 0xC → rsp_resp=2'b10 routed to the issuing requester only.
- ARESET pulsed while in RR with rvalid pending:
  - No rsp_valid.
  - All m_axi valids and readies are 0 the next cycle.
  - rr_ptr is 0; the next command is granted normally.
- With TRAFFICGEN_SCHED_ADDR_CHECK_EN: read 0x10 and write 0x6 → DECERR after 1 cycle, rdata=0, zero AXI handshakes. Without the macro the same commands reach the bus.
